// File: rtl/aes_pkg.sv
// Shared types, constants and GF helpers for the composite-field AES-128 encryptor.
// The S-box works in GF((2^4)^2): GF(16) uses w^4 = w + 1, and the extension uses Y^2 = Y + LAMBDA.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    localparam logic [3:0] NR = 4'd10;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Field element Y is 0xa2 and w is 0xe1 (both in AES-field coordinates).
    // Column i is the image of input bit i.
    localparam logic [3:0]      LAMBDA    = 4'hc;
    localparam logic [7:0][7:0] ISO_M     = {8'hb2, 8'h53, 8'he2, 8'h5f,
                                             8'h3f, 8'h37, 8'h40, 8'h01};
    // This matrix combines the inverse isomorphism with the linear part of the affine transform.
    localparam logic [7:0][7:0] INV_AFF_M = {8'h5e, 8'h3e, 8'h37, 8'h52,
                                             8'h84, 8'hb2, 8'hb4, 8'h1f};
    localparam logic [7:0]      AFF_C     = 8'h63;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [3:0] idx;
        idx = r - 4'd1;
        return (r != 4'd0 && r <= NR) ? RCON[idx] : 8'h00;
    endfunction

    function automatic logic [7:0] gf_mat8(input logic [7:0][7:0] m, input logic [7:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) acc ^= m[i];
        return acc;
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, t;
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p ^= t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] k);
        return {k[3], k[3] ^ k[1], k[2], k[2] ^ k[0]};
    endfunction

    // a^-1 = a^14 = a^2 * a^4 * a^8; zero maps to zero as AES requires
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_sq(a);
        a4 = gf4_sq(a2);
        a8 = gf4_sq(a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mixcolumn(input word_t col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_composite_enc_sbox.sv
// Combinational AES S-box: map to GF((2^4)^2), invert there, then map back and apply the affine transform.
module aes_sbox_composite
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] c, ci;
    logic [3:0] ah, al, d, di;

    assign c  = gf_mat8(ISO_M, x);
    assign ah = c[7:4];
    assign al = c[3:0];
    // (ah*Y + al)^-1 = ah*d^-1 * Y + (ah + al)*d^-1
    assign d  = gf4_mul(gf4_sq(ah), LAMBDA) ^ gf4_mul(ah, al) ^ gf4_sq(al);
    assign di = gf4_inv(d);
    assign ci = {gf4_mul(ah, di), gf4_mul(ah ^ al, di)};
    assign y  = gf_mat8(INV_AFF_M, ci) ^ AFF_C;

endmodule

// File: rtl/aes_composite_enc.sv
// Iterative AES-128 encryptor that computes one round per clock.
// The round key is expanded on the fly from the previous round key.
module aes_composite_enc
    import aes_pkg::*;
(
    input  logic   CLK,
    input  logic   RSTn,
    input  block_t Kin,
    input  block_t Din,
    output block_t Dout,
    input  logic   Krdy,
    input  logic   Drdy,
    output logic   Kvld,
    output logic   Dvld,
    input  logic   EN,
    output logic   BSY
);
    block_t     key_q, rk_q, st_q, dout_q;
    logic [3:0] rnd_q;
    logic       bsy_q, kvld_q, dvld_q;

    block_t     sb, sr, mc, rnd_out;
    word_t      w3_rot, w3_sub, t_word, n0, n1, n2, n3;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox_composite u_sbox (.x(st_q[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end

    // Byte index is row + 4*col; ShiftRows pulls row r from column (c + r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        end
        assign mc[127-32*c -: 32] = mixcolumn(sr[127-32*c -: 32]);
    end

    assign w3_rot = {rk_q[23:0], rk_q[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_ksbox
        aes_sbox_composite u_sbox (.x(w3_rot[31-8*i -: 8]), .y(w3_sub[31-8*i -: 8]));
    end

    assign t_word  = w3_sub ^ {rcon(rnd_q), 24'h0};
    assign n0      = rk_q[127:96] ^ t_word;
    assign n1      = rk_q[95:64]  ^ n0;
    assign n2      = rk_q[63:32]  ^ n1;
    assign n3      = rk_q[31:0]   ^ n2;
    assign rnd_out = ((rnd_q == NR) ? sr : mc) ^ {n0, n1, n2, n3};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_q  <= '0;
            rk_q   <= '0;
            st_q   <= '0;
            dout_q <= '0;
            rnd_q  <= '0;
            bsy_q  <= 1'b0;
            kvld_q <= 1'b0;
            dvld_q <= 1'b0;
        end else begin
            kvld_q <= 1'b0;
            dvld_q <= 1'b0;
            if (EN) begin
                if (Krdy && !bsy_q) begin
                    key_q  <= Kin;
                    rk_q   <= Kin;
                    kvld_q <= 1'b1;
                end else if (Drdy && !bsy_q) begin
                    st_q  <= Din ^ key_q;
                    rk_q  <= key_q;
                    rnd_q <= 4'd1;
                    bsy_q <= 1'b1;
                end else if (bsy_q) begin
                    st_q <= rnd_out;
                    rk_q <= {n0, n1, n2, n3};
                    if (rnd_q == NR) begin
                        dout_q <= rnd_out;
                        dvld_q <= 1'b1;
                        bsy_q  <= 1'b0;
                        rnd_q  <= 4'd0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
            end
        end
    end

    assign Dout = dout_q;
    assign Kvld = kvld_q;
    assign Dvld = dvld_q;
    assign BSY  = bsy_q;

endmodule

// File: tb/tb_aes_composite_enc.sv
// Scoreboard bench for aes_composite_enc. It uses FIPS-197 vectors and checks the control-corner cases and the standalone S-box.
module tb_aes_composite_enc;
    import aes_pkg::*;

    logic   CLK = 1'b0, RSTn = 1'b0, Krdy = 1'b0, Drdy = 1'b0, EN = 1'b1;
    block_t Kin = '0, Din = '0, Dout;
    logic   Kvld, Dvld, BSY;
    logic [7:0] sb_x, sb_y;

    always #5 CLK = ~CLK;

    aes_composite_enc dut (
        .CLK(CLK), .RSTn(RSTn), .Kin(Kin), .Din(Din), .Dout(Dout),
        .Krdy(Krdy), .Drdy(Drdy), .Kvld(Kvld), .Dvld(Dvld), .EN(EN), .BSY(BSY)
    );

    aes_sbox_composite u_sbox (.x(sb_x), .y(sb_y));

    localparam block_t K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t P1 = 128'h00112233445566778899aabbccddeeff;
    localparam block_t C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam block_t C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam block_t C4 = 128'hc6a13b37878f5b826f4f8162a1c8d879;

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct { block_t ct; int due; } exp_t;
    exp_t sb_q[$];
    exp_t exp_e;
    int   n_vec = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RSTn && Dvld) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_dvld", Dvld, 1'b0);
            end else begin
                exp_e = sb_q.pop_front();
                chk("dout", Dout, exp_e.ct);
                chk("latency", 128'(cyc), 128'(exp_e.due));
            end
        end
    end

    task automatic load_key(input block_t k);
        @(negedge CLK); Kin = k; Krdy = 1'b1;
        @(negedge CLK); Krdy = 1'b0;
        chk("kvld_pulse", Kvld, 1'b1);
        @(negedge CLK);
        chk("kvld_clear", Kvld, 1'b0);
    endtask

    // stall_at >= 0 drops EN for 3 cycles; glitch strobes Krdy/Drdy while busy
    task automatic encrypt(input block_t pt, input block_t ct, input int stall_at,
                           input bit glitch, output int bsy_cycles);
        int kv;
        bit done;
        kv = 0; done = 1'b0; bsy_cycles = 0;
        @(negedge CLK); Din = pt; Drdy = 1'b1;
        sb_q.push_back('{ct, cyc + 11 + (stall_at >= 0 ? 3 : 0)});
        @(negedge CLK); Drdy = 1'b0;
        if (BSY) bsy_cycles++;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == stall_at)     EN = 1'b0;
            if (i == stall_at + 3) EN = 1'b1;
            if (glitch && i == 3) begin Drdy = 1'b1; Din = ~pt; Krdy = 1'b1; Kin = ~pt; end
            if (glitch && i == 4) begin Drdy = 1'b0; Krdy = 1'b0; end
            @(negedge CLK);
            if (Kvld) kv++;
            if (BSY)  bsy_cycles++;
            if (Dvld) done = 1'b1;
        end
        chk("done", done, 1'b1);
        if (glitch) chk("kvld_while_bsy", kv, 0);
    endtask

    initial begin
        int nb;
        repeat (2) @(negedge CLK);
        chk("rst_dout", Dout, '0);
        chk("rst_flags", {Kvld, Dvld, BSY}, 3'b000);
        RSTn = 1'b1;

        encrypt('0, C0, -1, 1'b0, nb);
        chk("bsy_len_nokey", nb, 10);
        load_key('0);
        encrypt('0, C0, -1, 1'b0, nb);
        chk("bsy_len", nb, 10);

        load_key(K1);
        encrypt(P1, C1, -1, 1'b0, nb);
        encrypt('0, C4, -1, 1'b1, nb);
        encrypt(P1, C1, -1, 1'b0, nb);

        load_key(K2);
        encrypt(P2, C2, -1, 1'b0, nb);

        load_key(K1);
        encrypt(P1, C1, 4, 1'b0, nb);
        chk("bsy_len_stall", nb, 13);

        @(negedge CLK); Din = P2; Drdy = 1'b1;
        @(negedge CLK); Drdy = 1'b0;
        repeat (4) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk("abort_bsy", BSY, 1'b0);
        chk("abort_dvld", Dvld, 1'b0);
        chk("abort_dout", Dout, '0);
        @(negedge CLK); RSTn = 1'b1;

        @(negedge CLK); Kin = K2; Din = P1; Krdy = 1'b1; Drdy = 1'b1;
        @(negedge CLK); Krdy = 1'b0; Drdy = 1'b0;
        chk("both_kvld", Kvld, 1'b1);
        chk("both_bsy", BSY, 1'b0);
        repeat (12) @(negedge CLK);
        chk("both_bsy_later", BSY, 1'b0);
        encrypt(P2, C2, -1, 1'b0, nb);

        for (int i = 0; i < 256; i++) begin
            sb_x = 8'(i);
            #1;
            chk("sbox", sb_y, sbox_rows[i / 16][127 - 8 * (i % 16) -: 8]);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
